mult_div_unit: RTL and testbench
================================

# mult_div_unit

E-stage multiply/divide unit with the HI/LO register pair for the pipelined MIPS core. It accepts mult/multu/div/divu, mthi/mtlo and mfhi/mflo from the E stage. It produces the `start` and `busy` signals the hazard unit consumes: while either is high, the hazard unit stalls any HI/LO-class instruction in D. Results land in HI/LO after a fixed multi-cycle latency.

## Interface
- `MULT_CYCLES`, default 5: busy duration for mult/multu; must be ≥1.
- `DIV_CYCLES`, default 10: busy duration for div/divu; must be ≥1.
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high. Clears all state immediately.
- `md_valid` input 1: E-stage instruction is SPECIAL (opcode 000000) and is a valid, non-bubble instruction.
- `funct` input 6: E-stage `Instr[5:0]`.
- `src_a` input 32: forwarded rs value from E (multiplicand/dividend, mthi/mtlo data).
- `src_b` input 32: forwarded rt value from E (multiplier/divisor).
- `start` output 1: combinational. High when `md_valid` is high and `funct` is 011000, 011001, 011010 or 011011.
- `busy` output 1: registered. High while an operation is in flight.
- `hi` output 32: current HI register.
- `lo` output 32: current LO register.
- `hilo_out` output 32: combinational mfhi/mflo result.
  - `hi` when `md_valid` and funct is 010000.
  - `lo` when `md_valid` and funct is 010010.
  - 0 otherwise.

## Operation
- State:
  - `cnt` (width `$clog2(max(MULT_CYCLES, DIV_CYCLES)+1)`).
  - Pending result registers `res_hi`/`res_lo`.
  - `res_wr` flag.
  - HI, LO.
- `busy = (cnt != 0)`.
- Start edge (`start` high, `busy` low):
  - mult: {res_hi,res_lo} ← `$signed(src_a) * $signed(src_b)`, 64-bit.
  - multu: the same product with both operands unsigned.
  - div: res_lo ← signed quotient, truncated toward zero; res_hi ← remainder, which takes the sign of the dividend.
  - divu: the unsigned quotient and remainder.
  - Special case `src_a`=0x80000000, `src_b`=0xFFFFFFFF under div: quotient 0x80000000, remainder 0.
  - `src_b`=0 under div or divu: `res_wr` ← 0, so HI/LO are left unchanged. The full `DIV_CYCLES` busy period still elapses.
  - All other starts: `res_wr` ← 1.
  - `cnt` ← `MULT_CYCLES` for mult/multu, or `DIV_CYCLES` for div/divu.
- Countdown: each edge with `cnt != 0`, `cnt` ← `cnt - 1`. On the 1→0 transition, if `res_wr` is set, HI ← `res_hi` and LO ← `res_lo`.
- mthi/mtlo (funct 010001/010011, `md_valid`, `busy` low): HI or LO ← `src_a` on the edge.
- While `busy` is high, `start`, mthi and mtlo are ignored: no state change, counter undisturbed. The hazard unit never lets this happen in correct operation; the bench checks it as a protection path.
- `start` stays a pure decode of E and is not gated by `busy`, so the hazard unit sees it in the start cycle itself.

## Timing
- Reset values: `busy`=0, `cnt`=0, HI=0, LO=0, `res_hi`=0, `res_lo`=0, `res_wr`=0.
- Combinational outputs follow their inputs under reset: `start` from decode, `hilo_out` reads the zeroed HI/LO.
- Start accepted at edge T:
  - `busy`=1 during cycles T+1 … T+N.
  - HI/LO updated at the edge ending cycle T+N.
  - `busy`=0 in cycle T+N+1, where the new values are visible on `hi`, `lo` and `hilo_out`.
- The hazard stall covers the start cycle (via `start`) plus the N busy cycles. An mfhi in D can therefore reach E no earlier than cycle T+N+1, and reads the updated value.
- mthi/mtlo takes effect on its E edge; an mfhi in E in the next cycle sees the new value. There is no internal forwarding within the same cycle.
- Reset asserted mid-operation: `cnt` → 0 and `busy` → 0 asynchronously. The pending result is discarded and HI/LO = 0.
- Back-to-back starts: a new start is accepted in cycle T+N+1, when `busy` is already low.

## Test plan
- **mult:** `src_a`=0xFFFFFFFF, `src_b`=2.
  - `busy` is high for exactly 5 cycles.
  - Afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - multu with the same operands gives HI=0x00000001, LO=0xFFFFFFFE.
- **Signed and unsigned divide:**
  - div −7 / 2 (0xFFFFFFF9, 2): after 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu 7 / 2: LO=3, HI=1.
- **Divide by zero:** preload HI=0x11111111 and LO=0x22222222 via mthi/mtlo, then div x/0.
  - `busy` is high for 10 cycles.
  - HI/LO are unchanged afterwards.
- **Ignored accesses while busy:** during a mult busy window, drive mtlo 0xDEADBEEF and a second mult.
  - Both are ignored.
  - `busy` falls on schedule with the first product in HI/LO.
  - `start` still pulses combinationally.
- **Reset mid-operation:** assert `reset` asynchronously (between edges) in the 3rd busy cycle of a div.
  - `busy`, HI and LO go to 0 immediately.
  - After release, the old result never appears.
- **mfhi/mflo read:** after mthi 0xA5A5A5A5, present funct 010000 with `md_valid`.
  - `hilo_out`=0xA5A5A5A5.
  - With `md_valid`=0, `hilo_out`=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit with HI/LO pair; results commit after a fixed
// MULT_CYCLES/DIV_CYCLES latency while busy drives the hazard stall.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_valid,
    input  logic [5:0]  funct,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] hilo_out
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   res_hi_q, res_hi_d, res_lo_q, res_lo_d;
    logic          res_wr_q, res_wr_d;

    logic          is_mult, is_div, is_signed;
    logic [63:0]   prod;
    logic          a_neg, b_neg;
    logic [31:0]   mag_a, mag_b, divisor, uq, ur, quot, rem;

    assign is_mult   = (funct == F_MULT) || (funct == F_MULTU);
    assign is_div    = (funct == F_DIV)  || (funct == F_DIVU);
    assign is_signed = ~funct[0];
    assign start     = md_valid && (is_mult || is_div);
    assign busy      = (cnt_q != '0);
    assign hi        = hi_q;
    assign lo        = lo_q;

    always_comb begin
        if (md_valid && funct == F_MFHI)
            hilo_out = hi_q;
        else if (md_valid && funct == F_MFLO)
            hilo_out = lo_q;
        else
            hilo_out = '0;
    end

    // Low 64 bits of the sign/zero-extended 64x64 product are the exact result.
    always_comb begin
        if (is_signed)
            prod = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
        else
            prod = {32'b0, src_a} * {32'b0, src_b};
    end

    // Divide on magnitudes then restore signs; this yields 0x80000000/-1 =
    // 0x80000000 rem 0 without a special case, and avoids divide-by-zero X.
    always_comb begin
        a_neg   = is_signed & src_a[31];
        b_neg   = is_signed & src_b[31];
        mag_a   = a_neg ? -src_a : src_a;
        mag_b   = b_neg ? -src_b : src_b;
        divisor = (mag_b == '0) ? 32'd1 : mag_b;
        uq      = mag_a / divisor;
        ur      = mag_a % divisor;
        quot    = (a_neg ^ b_neg) ? -uq : uq;
        rem     = a_neg ? -ur : ur;
    end

    always_comb begin
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        res_wr_d = res_wr_q;
        if (!busy) begin
            if (start) begin
                if (is_mult) begin
                    {res_hi_d, res_lo_d} = prod;
                    res_wr_d = 1'b1;
                    cnt_d    = CW'(MULT_CYCLES);
                end else begin
                    res_lo_d = quot;
                    res_hi_d = rem;
                    res_wr_d = (src_b != '0);
                    cnt_d    = CW'(DIV_CYCLES);
                end
            end else if (md_valid && funct == F_MTHI) begin
                hi_d = src_a;
            end else if (md_valid && funct == F_MTLO) begin
                lo_d = src_a;
            end
        end else begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1) && res_wr_q) begin
                hi_d = res_hi_q;
                lo_d = res_lo_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            res_wr_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            res_wr_q <= res_wr_d;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, results, divide-by-zero,
// ignored accesses while busy, async reset mid-operation and mfhi/mflo reads.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        md_valid;
    logic [5:0]  funct;
    logic [31:0] src_a, src_b;
    logic        start, busy;
    logic [31:0] hi, lo, hilo_out;

    int n_cmp = 0;
    int n_err = 0;
    int cyc;
    logic saw_busy;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .md_valid (md_valid),
        .funct    (funct),
        .src_a    (src_a),
        .src_b    (src_b),
        .start    (start),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo),
        .hilo_out (hilo_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one instruction in E for a single cycle, return 1ns after its edge.
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        md_valid = 1'b1;
        funct    = f;
        src_a    = a;
        src_b    = b;
        @(posedge clk);
        #1;
        md_valid = 1'b0;
        funct    = 6'd0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        reset    = 1'b1;
        md_valid = 1'b1;
        funct    = 6'b011000;
        src_a    = 32'h0;
        src_b    = 32'h0;
        #1;
        chk("rst_start_decode", {31'b0, start}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        funct = 6'b010000;
        #1;
        chk("rst_hilo_out", hilo_out, 32'h0);
        md_valid = 1'b0;
        funct    = 6'd0;
        #9;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // mult signed
        md_valid = 1'b1; funct = 6'b011000; src_a = 32'hFFFFFFFF; src_b = 32'd2;
        #1;
        chk("mult_start", {31'b0, start}, 32'd1);
        issue(6'b011000, 32'hFFFFFFFF, 32'd2);
        chk("mult_busy_t1", {31'b0, busy}, 32'd1);
        chk("mult_hi_unchanged", hi, 32'h0);
        wait_idle(cyc);
        chk("mult_cycles", cyc, 32'd5);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFE);
        md_valid = 1'b1; funct = 6'b010000;
        #1;
        chk("mfhi_after_mult", hilo_out, 32'hFFFFFFFF);
        funct = 6'b010010;
        #1;
        chk("mflo_after_mult", hilo_out, 32'hFFFFFFFE);
        md_valid = 1'b0; funct = 6'd0;

        // back-to-back multu, issued in the first idle cycle
        issue(6'b011001, 32'hFFFFFFFF, 32'd2);
        wait_idle(cyc);
        chk("multu_cycles", cyc, 32'd5);
        chk("multu_hi", hi, 32'h00000001);
        chk("multu_lo", lo, 32'hFFFFFFFE);

        // div -7 / 2
        issue(6'b011010, 32'hFFFFFFF9, 32'd2);
        wait_idle(cyc);
        chk("div_cycles", cyc, 32'd10);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);

        // div 7 / -2
        issue(6'b011010, 32'd7, 32'hFFFFFFFE);
        wait_idle(cyc);
        chk("div_negb_lo", lo, 32'hFFFFFFFD);
        chk("div_negb_hi", hi, 32'h00000001);

        // divu 7 / 2
        issue(6'b011011, 32'd7, 32'd2);
        wait_idle(cyc);
        chk("divu_cycles", cyc, 32'd10);
        chk("divu_lo", lo, 32'd3);
        chk("divu_hi", hi, 32'd1);

        // divu with top bit set must not be treated as signed
        issue(6'b011011, 32'hFFFFFFF9, 32'd2);
        wait_idle(cyc);
        chk("divu_big_lo", lo, 32'h7FFFFFFC);
        chk("divu_big_hi", hi, 32'd1);

        // signed overflow case
        issue(6'b011010, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(cyc);
        chk("div_ovf_lo", lo, 32'h80000000);
        chk("div_ovf_hi", hi, 32'h0);

        // divide by zero after preload
        issue(6'b010001, 32'h11111111, 32'h0);
        chk("mthi_next_cycle", hi, 32'h11111111);
        chk("mthi_busy", {31'b0, busy}, 32'd0);
        issue(6'b010011, 32'h22222222, 32'h0);
        chk("mtlo_next_cycle", lo, 32'h22222222);
        issue(6'b011010, 32'd5, 32'd0);
        wait_idle(cyc);
        chk("div0_cycles", cyc, 32'd10);
        chk("div0_hi", hi, 32'h11111111);
        chk("div0_lo", lo, 32'h22222222);
        issue(6'b011011, 32'd9, 32'd0);
        wait_idle(cyc);
        chk("divu0_cycles", cyc, 32'd10);
        chk("divu0_hi", hi, 32'h11111111);
        chk("divu0_lo", lo, 32'h22222222);

        // ignored accesses during a mult busy window
        issue(6'b011000, 32'd3, 32'd4);
        md_valid = 1'b1; funct = 6'b010011; src_a = 32'hDEADBEEF;
        #1;
        chk("busy_mtlo_nostart", {31'b0, start}, 32'd0);
        @(posedge clk);
        #1;
        chk("busy_mtlo_ignored", lo, 32'h22222222);
        funct = 6'b011000; src_a = 32'd5; src_b = 32'd6;
        #1;
        chk("busy_start_pulse", {31'b0, start}, 32'd1);
        @(posedge clk);
        #1;
        md_valid = 1'b0; funct = 6'd0;
        wait_idle(cyc);
        chk("busy_remaining", cyc, 32'd3);
        chk("busy_first_lo", lo, 32'd12);
        chk("busy_first_hi", hi, 32'd0);

        // async reset in the 3rd busy cycle of a div
        issue(6'b010001, 32'h0BADF00D, 32'h0);
        issue(6'b011010, 32'd100, 32'd7);
        @(posedge clk);
        #1;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        chk("rst_mid_hi", hi, 32'h0);
        chk("rst_mid_lo", lo, 32'h0);
        #1;
        reset    = 1'b0;
        saw_busy = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            if (busy) saw_busy = 1'b1;
        end
        chk("rst_no_busy_after", {31'b0, saw_busy}, 32'd0);
        chk("rst_no_old_hi", hi, 32'h0);
        chk("rst_no_old_lo", lo, 32'h0);

        // mfhi / mflo read path
        issue(6'b010001, 32'hA5A5A5A5, 32'h0);
        md_valid = 1'b1; funct = 6'b010000;
        #1;
        chk("mfhi_read", hilo_out, 32'hA5A5A5A5);
        funct = 6'b010010;
        #1;
        chk("mflo_read", hilo_out, 32'h0);
        md_valid = 1'b0; funct = 6'b010000;
        #1;
        chk("mfhi_invalid", hilo_out, 32'h0);
        md_valid = 1'b1; funct = 6'b010001;
        #1;
        chk("mthi_no_read", hilo_out, 32'h0);
        md_valid = 1'b0; funct = 6'd0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
